// File: rtl/lpm_fifo_dc_pkg.sv
// Shared definitions for the dual-clock LPM FIFO pointer stages: mode names,
// synchroniser depth limits and Gray/binary conversion helpers.
package lpm_fifo_dc_pkg;

   localparam string LPM_FIFO_DC_MODE_READ  = "READ";
   localparam string LPM_FIFO_DC_MODE_WRITE = "WRITE";

   localparam int LPM_FIFO_DC_SYNC_MIN = 2;
   localparam int LPM_FIFO_DC_SYNC_MAX = 4;

   // Helpers work on a 32-bit container; callers zero-extend their pointer and
   // size-cast the result back, which is exact for any width up to 32.
   localparam int LPM_FIFO_DC_FN_W = 32;

   function automatic logic [LPM_FIFO_DC_FN_W-1:0] bin2gray(
      input logic [LPM_FIFO_DC_FN_W-1:0] i_bin
   );
      return i_bin ^ (i_bin >> 1);
   endfunction

   function automatic logic [LPM_FIFO_DC_FN_W-1:0] gray2bin(
      input logic [LPM_FIFO_DC_FN_W-1:0] i_gray
   );
      logic [LPM_FIFO_DC_FN_W-1:0] w_bin;
      w_bin[LPM_FIFO_DC_FN_W-1] = i_gray[LPM_FIFO_DC_FN_W-1];
      for (int i = LPM_FIFO_DC_FN_W - 2; i >= 0; i--) begin
         w_bin[i] = w_bin[i+1] ^ i_gray[i];
      end
      return w_bin;
   endfunction

endpackage

// File: rtl/lpm_fifo_dc_sync_pipe.sv
// Width/depth-parameterised flop chain with asynchronous clear, used to bring
// the remote Gray pointer into the local clock domain.
module lpm_fifo_dc_sync_pipe
   import lpm_fifo_dc_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = LPM_FIFO_DC_SYNC_MIN
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/lpm_fifo_dc_usedw_sync.sv
// Per-domain pointer and used-words stage of the dual-clock LPM FIFO.
// Optional simulation checker: define LPM_FIFO_DC_GRAY_CHECK_EN.
module lpm_fifo_dc_usedw_sync
   import lpm_fifo_dc_pkg::*;
#(
   parameter int    lpm_widthad = 1,
   parameter string lpm_mode    = "READ",
   parameter int    sync_stages = 2
) (
   input  logic                   clock,
   input  logic                   aclr,
   input  logic                   inc,
   input  logic [lpm_widthad:0]   remote_ptr_gray,
   output logic [lpm_widthad:0]   local_ptr_gray,
   output logic [lpm_widthad:0]   local_ptr_bin,
   output logic [lpm_widthad-1:0] usedw
);

   localparam int PW       = lpm_widthad + 1;
   localparam bit IS_WRITE = (lpm_mode == LPM_FIFO_DC_MODE_WRITE);
   localparam bit IS_READ  = (lpm_mode == LPM_FIFO_DC_MODE_READ);
   localparam bit PARAM_OK = (IS_READ || IS_WRITE) &&
                             (sync_stages >= LPM_FIFO_DC_SYNC_MIN) &&
                             (sync_stages <= LPM_FIFO_DC_SYNC_MAX);
   // Keeps the pipe elaboratable even when the parameter check fires.
   localparam int SYNC_N   = (sync_stages < LPM_FIFO_DC_SYNC_MIN) ? LPM_FIFO_DC_SYNC_MIN :
                             (sync_stages > LPM_FIFO_DC_SYNC_MAX) ? LPM_FIFO_DC_SYNC_MAX :
                             sync_stages;

   logic [PW-1:0]          r_local_bin;
   logic [PW-1:0]          r_local_gray;
   logic [PW-1:0]          r_remote_bin;
   logic [lpm_widthad-1:0] r_usedw;

   logic [PW-1:0] w_next_bin;
   logic [PW-1:0] w_next_gray;
   logic [PW-1:0] w_remote_gray_sync;
   logic [PW-1:0] w_remote_bin;
   logic [PW-1:0] w_diff;

`ifndef SYNTHESIS
   generate
      if (!PARAM_OK) begin : g_param_err
         initial begin
            $display("Error! %m: illegal lpm_mode or sync_stages");
            $stop;
         end
      end
   endgenerate
`endif

   assign w_next_bin  = r_local_bin + PW'(1);
   assign w_next_gray = PW'(bin2gray(32'(w_next_bin)));

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         r_local_bin  <= '0;
         r_local_gray <= '0;
      end else if (inc) begin
         r_local_bin  <= w_next_bin;
         r_local_gray <= w_next_gray;
      end
   end

   lpm_fifo_dc_sync_pipe #(
      .WIDTH (PW),
      .DEPTH (SYNC_N)
   ) u_sync_pipe (
      .clock (clock),
      .aclr  (aclr),
      .i_d   (remote_ptr_gray),
      .o_q   (w_remote_gray_sync)
   );

   assign w_remote_bin = PW'(gray2bin(32'(w_remote_gray_sync)));

   // Full depth wraps to 0 after truncation; downstream flags never let it be reached.
   assign w_diff = IS_WRITE ? (r_local_bin - r_remote_bin) : (r_remote_bin - r_local_bin);

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         r_remote_bin <= '0;
         r_usedw      <= '0;
      end else begin
         r_remote_bin <= w_remote_bin;
         r_usedw      <= lpm_widthad'(w_diff);
      end
   end

   assign local_ptr_bin  = r_local_bin;
   assign local_ptr_gray = r_local_gray;
   assign usedw          = r_usedw;

`ifdef LPM_FIFO_DC_GRAY_CHECK_EN
   logic [PW-1:0]          r_chk_prev_gray;
   logic [lpm_widthad-1:0] r_chk_usedw;
   logic [PW-1:0]          r_chk_loc1;
   logic [PW-1:0]          r_chk_loc2;

   // usedw seen now came from the local pointer two samples back, so a READ-side
   // drop is only legal when that pointer moved relative to the one before it.
   always @(posedge clock or posedge aclr) begin
      if (aclr) begin
         r_chk_prev_gray <= '0;
         r_chk_usedw     <= '0;
         r_chk_loc1      <= '0;
         r_chk_loc2      <= '0;
      end else begin
         if ($countones(remote_ptr_gray ^ r_chk_prev_gray) > 1)
            $display("Error! Non-Gray remote pointer transition. time=%0t %m", $time);
         if (IS_READ && (usedw < r_chk_usedw) && (r_chk_loc1 == r_chk_loc2))
            $display("Error! READ usedw decreased without local inc. time=%0t %m", $time);
         r_chk_prev_gray <= remote_ptr_gray;
         r_chk_usedw     <= usedw;
         r_chk_loc1      <= local_ptr_bin;
         r_chk_loc2      <= r_chk_loc1;
      end
   end
`endif

endmodule
